// File: rtl/e_mdu_seq.sv
// e_mdu_seq: multi-cycle multiply/divide unit for the E stage, owner of the HI/LO registers
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   start    E-stage instruction is an MDU op
//   op       0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
//   A, B     rs / rt operands
//   req      exception/interrupt flush of the E-stage instruction
//   busy     multi-cycle operation in progress
//   stall_md stall request to hazard control
//   HI, LO   architectural HI/LO registers
//   mdu_out  mfhi/mflo read data
module e_mdu_seq #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             req,
   output logic             busy,
   output logic             stall_md,
   output logic [WIDTH-1:0] HI,
   output logic [WIDTH-1:0] LO,
   output logic [WIDTH-1:0] mdu_out
);
   localparam int MAXC = MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = MAXC > 1 ? $clog2(MAXC) : 1;
   typedef enum logic {IDLE, RUN} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, phi_q, phi_d, plo_q, plo_d;
   logic [2*WIDTH-1:0] ea, eb, prod;
   logic [WIDTH-1:0] dvs, sq, sr, uq, ur, res_hi, res_lo;
   logic is_mul, dz, ovf, go, accept, done;
   always_comb begin
      is_mul = ~op[1];
      // operands extended to 2*WIDTH: sign for mult, zero for multu; low 2*WIDTH bits of the product are then exact
      ea     = {{WIDTH{A[WIDTH-1] & ~op[0]}}, A};
      eb     = {{WIDTH{B[WIDTH-1] & ~op[0]}}, B};
      prod   = ea * eb;
      dz     = (B == '0);
      ovf    = ~op[0] & (A == {1'b1, {(WIDTH-1){1'b0}}}) & (B == '1);
      // dividing by 1 on overflow yields exactly most-negative / 0; divide-by-zero results are substituted below
      dvs    = (dz | ovf) ? WIDTH'(1) : B;
      sq     = $signed(A) / $signed(dvs);
      sr     = $signed(A) % $signed(dvs);
      uq     = A / dvs;
      ur     = A % dvs;
      res_hi = is_mul ? prod[2*WIDTH-1:WIDTH] : dz ? A : op[0] ? ur : sr;
      res_lo = is_mul ? prod[WIDTH-1:0] : dz ? '1 : op[0] ? uq : sq;
      go     = (state_q == IDLE) & start & ~req;
      accept = go & ~op[2];
      done   = (state_q == RUN) & (cnt_q == '0);
      state_d = accept ? RUN : done ? IDLE : state_q;
      cnt_d  = accept ? (is_mul ? CW'(MULT_CYCLES - 1) : CW'(DIV_CYCLES - 1))
             : ((state_q == RUN) & ~done) ? cnt_q - 1'b1 : cnt_q;
      phi_d  = accept ? res_hi : phi_q;
      plo_d  = accept ? res_lo : plo_q;
      hi_d   = done ? phi_q : (go & (op == 3'd4)) ? A : hi_q;
      lo_d   = done ? plo_q : (go & (op == 3'd5)) ? A : lo_q;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         phi_q   <= '0;
         plo_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         phi_q   <= phi_d;
         plo_q   <= plo_d;
      end
   end
   assign busy     = (state_q == RUN);
   assign stall_md = (busy | (start & ~op[2] & ~req)) & start;
   assign HI       = hi_q;
   assign LO       = lo_q;
   assign mdu_out  = (op == 3'd6) ? hi_q : (op == 3'd7) ? lo_q : '0;
endmodule

// File: tb/tb_e_mdu_seq.sv
// tb_e_mdu_seq: self-checking bench for e_mdu_seq (32-bit default instance plus a 16-bit instance)
module tb_e_mdu_seq;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic reset, start, req, busy, stall_md;
   logic [2:0] op;
   logic [31:0] a, b, hi, lo, mdu_out;
   logic s_start, s_req, s_busy, s_stall;
   logic [2:0] s_op;
   logic [15:0] s_a, s_b, s_hi, s_lo, s_out;
   int checks = 0;
   int failures = 0;
   logic [63:0] exp_q[$];
   e_mdu_seq dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .A(a), .B(b), .req(req),
      .busy(busy), .stall_md(stall_md), .HI(hi), .LO(lo), .mdu_out(mdu_out)
   );
   e_mdu_seq #(.WIDTH(16), .MULT_CYCLES(3), .DIV_CYCLES(4)) u16 (
      .clk(clk), .reset(reset), .start(s_start), .op(s_op), .A(s_a), .B(s_b), .req(s_req),
      .busy(s_busy), .stall_md(s_stall), .HI(s_hi), .LO(s_lo), .mdu_out(s_out)
   );
   function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      longint sx, sy, mx, my, q, r;
      logic [63:0] p;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      if (o == 3'd0) begin
         p = sx * sy;
         return p;
      end
      if (o == 3'd1) begin
         p = {32'd0, x} * {32'd0, y};
         return p;
      end
      if (y == 32'd0) return {x, 32'hFFFF_FFFF};
      if (o == 3'd3) return {x % y, x / y};
      mx = sx < 0 ? -sx : sx;
      my = sy < 0 ? -sy : sy;
      q = mx / my;
      r = mx % my;
      if ((sx < 0) != (sy < 0)) q = -q;
      if (sx < 0) r = -r;
      return {r[31:0], q[31:0]};
   endfunction
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, input logic req_run,
                        output int cyc, output logic [63:0] mid, output logic [63:0] fin);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y; req = 1'b0;
      @(negedge clk);
      start = 1'b0; req = req_run; mid = {hi, lo}; cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      req = 1'b0;
      fin = {hi, lo};
   endtask
   task automatic test_reset;
      #3;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0 || s_busy !== 1'b0) begin
         failures++;
         $display("FAIL reset busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      @(negedge clk);
      reset = 1'b1;
   endtask
   task automatic test_mult;
      int cyc; logic [63:0] mid, fin, e, prev;
      prev = {hi, lo};
      exp_q.push_back(model(3'd0, 32'hFFFF_FFFE, 32'd3));
      issue(3'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, cyc, mid, fin);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 5) begin failures++; $display("FAIL mult_busy_cycles got=%0d exp=5", cyc); end
      checks++;
      if (mid !== prev) begin failures++; $display("FAIL mult_hilo_during_busy got=%h exp=%h", mid, prev); end
      checks++;
      if (fin !== e) begin failures++; $display("FAIL mult_result got=%h exp=%h", fin, e); end
   endtask
   task automatic test_multu_divu;
      int cyc; logic [63:0] mid, fin, e;
      exp_q.push_back(model(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF));
      issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, cyc, mid, fin);
      e = exp_q.pop_front();
      checks++;
      if (fin !== e) begin failures++; $display("FAIL multu_result got=%h exp=%h", fin, e); end
      exp_q.push_back(model(3'd3, 32'd7, 32'd0));
      issue(3'd3, 32'd7, 32'd0, 1'b0, cyc, mid, fin);
      e = exp_q.pop_front();
      checks++;
      if (cyc !== 10) begin failures++; $display("FAIL divu_busy_cycles got=%0d exp=10", cyc); end
      checks++;
      if (fin !== e) begin failures++; $display("FAIL divu_by_zero got=%h exp=%h", fin, e); end
   endtask
   task automatic test_div;
      int cyc; logic [63:0] mid, fin, e;
      logic [31:0] xs[3] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'hFFFF_FFFB};
      logic [31:0] ys[3] = '{32'd2, 32'hFFFF_FFFF, 32'd0};
      for (int i = 0; i < 3; i++) begin
         exp_q.push_back(model(3'd2, xs[i], ys[i]));
         issue(3'd2, xs[i], ys[i], 1'b0, cyc, mid, fin);
         e = exp_q.pop_front();
         checks++;
         if (fin !== e || cyc !== 10) begin
            failures++;
            $display("FAIL div_case%0d got=%h/%0d exp=%h/10", i, fin, cyc, e);
         end
      end
   endtask
   task automatic test_mfhi;
      @(negedge clk);
      op = 3'd6;
      #1;
      checks++;
      if (mdu_out !== hi) begin failures++; $display("FAIL mfhi got=%h exp=%h", mdu_out, hi); end
      op = 3'd7;
      #1;
      checks++;
      if (mdu_out !== lo) begin failures++; $display("FAIL mflo got=%h exp=%h", mdu_out, lo); end
      op = 3'd0;
      #1;
      checks++;
      if (mdu_out !== 32'd0) begin failures++; $display("FAIL mdu_out_other got=%h exp=0", mdu_out); end
   endtask
   task automatic test_req;
      int cyc; logic [63:0] mid, fin, e, prev;
      prev = {hi, lo};
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9; req = 1'b1;
      #1;
      checks++;
      if (stall_md !== 1'b0) begin failures++; $display("FAIL req_stall got=%b exp=0", stall_md); end
      @(negedge clk);
      op = 3'd4; a = 32'hDEAD_BEEF;
      @(negedge clk);
      start = 1'b0; req = 1'b0;
      checks++;
      if (busy !== 1'b0 || {hi, lo} !== prev) begin
         failures++;
         $display("FAIL req_suppress busy=%b hilo=%h exp busy=0 hilo=%h", busy, {hi, lo}, prev);
      end
      exp_q.push_back(model(3'd0, 32'h0001_2345, 32'hFFFF_0003));
      issue(3'd0, 32'h0001_2345, 32'hFFFF_0003, 1'b1, cyc, mid, fin);
      e = exp_q.pop_front();
      checks++;
      if (fin !== e || cyc !== 5) begin failures++; $display("FAIL req_during_run got=%h/%0d exp=%h/5", fin, cyc, e); end
   endtask
   task automatic test_back_to_back;
      int cyc; logic [63:0] e;
      int stall_bad = 0;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd1000; b = 32'hFFFF_FFF0;
      exp_q.push_back(model(3'd0, 32'd1000, 32'hFFFF_FFF0));
      @(negedge clk);
      a = 32'h0012_3456; b = 32'h0000_0100;
      exp_q.push_back(model(3'd0, 32'h0012_3456, 32'h0000_0100));
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         if (stall_md !== 1'b1) stall_bad++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e || cyc !== 5) begin failures++; $display("FAIL b2b_first got=%h/%0d exp=%h/5", {hi, lo}, cyc, e); end
      checks++;
      if (stall_bad !== 0 || stall_md !== 1'b1) begin failures++; $display("FAIL b2b_stall bad=%0d stall=%b exp 0/1", stall_bad, stall_md); end
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL b2b_no_bubble busy=%b exp=1", busy); end
      start = 1'b0;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e || cyc !== 5) begin failures++; $display("FAIL b2b_second got=%h/%0d exp=%h/5", {hi, lo}, cyc, e); end
   endtask
   task automatic test_mthi_busy;
      int cyc; logic [63:0] e;
      @(negedge clk);
      start = 1'b1; op = 3'd0; a = 32'd77; b = 32'd3;
      exp_q.push_back(model(3'd0, 32'd77, 32'd3));
      @(negedge clk);
      op = 3'd4; a = 32'h1234;
      cyc = 0;
      while (busy && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      e = exp_q.pop_front();
      checks++;
      if ({hi, lo} !== e) begin failures++; $display("FAIL mthi_ignored_busy got=%h exp=%h", {hi, lo}, e); end
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (hi !== 32'h1234 || busy !== 1'b0 || lo !== e[31:0]) begin
         failures++;
         $display("FAIL mthi_idle hi=%h busy=%b lo=%h exp 1234/0/%h", hi, busy, lo, e[31:0]);
      end
      @(negedge clk);
      start = 1'b1; op = 3'd5; a = 32'hCAFE_0001;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (lo !== 32'hCAFE_0001 || hi !== 32'h1234) begin failures++; $display("FAIL mtlo got=%h/%h exp 1234/cafe0001", hi, lo); end
   endtask
   task automatic test_reset_mid;
      int cyc; int bad = 0; logic [63:0] mid, fin, e;
      @(negedge clk);
      start = 1'b1; op = 3'd2; a = 32'd100; b = 32'd7;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      #2 reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
         failures++;
         $display("FAIL reset_mid busy=%b hi=%h lo=%h exp 0/0/0", busy, hi, lo);
      end
      reset = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
      end
      checks++;
      if (bad !== 0) begin failures++; $display("FAIL reset_discard bad_samples=%0d exp=0", bad); end
      exp_q.push_back(model(3'd3, 32'hFFFF_FFF0, 32'd9));
      issue(3'd3, 32'hFFFF_FFF0, 32'd9, 1'b0, cyc, mid, fin);
      e = exp_q.pop_front();
      checks++;
      if (fin !== e || cyc !== 10) begin failures++; $display("FAIL after_reset got=%h/%0d exp=%h/10", fin, cyc, e); end
   endtask
   task automatic test_random;
      int cyc; logic [63:0] mid, fin, e; logic [2:0] o; logic [31:0] x, y;
      for (int i = 0; i < 8; i++) begin
         o = 3'($urandom_range(0, 3));
         x = $urandom;
         y = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         exp_q.push_back(model(o, x, y));
         issue(o, x, y, 1'b0, cyc, mid, fin);
         e = exp_q.pop_front();
         checks++;
         if (fin !== e || cyc !== (o < 3'd2 ? 5 : 10)) begin
            failures++;
            $display("FAIL random%0d op=%0d a=%h b=%h got=%h/%0d exp=%h", i, o, x, y, fin, cyc, e);
         end
      end
   endtask
   task automatic test_width16;
      int cyc;
      logic [15:0] xs[2] = '{16'h8000, 16'h8000};
      logic [15:0] ys[2] = '{16'h8000, 16'hFFFF};
      logic [31:0] ex[2] = '{32'h4000_0000, 32'h0000_8000};
      int ec[2] = '{3, 4};
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         s_start = 1'b1; s_op = (i == 0) ? 3'd0 : 3'd2; s_a = xs[i]; s_b = ys[i];
         @(negedge clk);
         s_start = 1'b0;
         cyc = 0;
         while (s_busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
         end
         checks++;
         if ({s_hi, s_lo} !== ex[i] || cyc !== ec[i]) begin
            failures++;
            $display("FAIL w16_case%0d got=%h/%0d exp=%h/%0d", i, {s_hi, s_lo}, cyc, ex[i], ec[i]);
         end
      end
   endtask
   initial begin
      reset = 1'b0; start = 1'b0; req = 1'b0; op = 3'd0; a = '0; b = '0;
      s_start = 1'b0; s_req = 1'b0; s_op = 3'd0; s_a = '0; s_b = '0;
      test_reset;
      test_mult;
      test_multu_divu;
      test_div;
      test_mfhi;
      test_req;
      test_back_to_back;
      test_mthi_busy;
      test_reset_mid;
      test_random;
      test_width16;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/e_mdu_seq.md
Name: e_mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit for the E stage, next to the ALU.
- Owns the HI/LO registers.
- Executes mult/multu/div/divu over a configurable number of cycles, plus single-cycle mthi/mtlo.
- Drives a busy/stall indication to hazard control and a read port for mfhi/mflo.
- Honours an exception-request input so that an instruction flushed in E never modifies HI/LO.

Parameters:
- WIDTH, 32, operand/HI/LO width in bits (>= 8)
- MULT_CYCLES, 5, cycles busy is held for mult/multu (>= 1)
- DIV_CYCLES, 10, cycles busy is held for div/divu (>= 1)

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  E-stage instruction is an MDU op (qualified by op)
- op  input  3  0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 mfhi, 7 mflo
- A  input  WIDTH  rs operand
- B  input  WIDTH  rt operand
- req  input  1  exception/interrupt flush of the E-stage instruction this cycle
- busy  output  1  multi-cycle operation in progress
- stall_md  output  1  combinational: (busy | (start & op<=3 & ~req)) & start
- HI  output  WIDTH  current HI register
- LO  output  WIDTH  current LO register
- mdu_out  output  WIDTH  op==6 ? HI : op==7 ? LO : 0 (combinational)

Behaviour:
- Reset (reset==0, asynchronous): HI=0, LO=0, busy=0, counter=0, pending results=0, state IDLE.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, counter counts down.
- Accept: in IDLE, at a rising edge with start=1, op<=3 and req=0:
  - latch the result into pending_hi/pending_lo;
  - load counter with MULT_CYCLES-1 (ops 0,1) or DIV_CYCLES-1 (ops 2,3);
  - enter RUN.
- RUN: counter decrements each edge. On the edge where counter==0:
  - HI<=pending_hi, LO<=pending_lo;
  - return to IDLE.
  - busy is therefore high for exactly MULT_CYCLES or DIV_CYCLES cycles, and HI/LO are visible the cycle busy falls.
- Arithmetic:
  - mult: signed 2*WIDTH product, HI=upper WIDTH bits, LO=lower.
  - multu: same, unsigned.
  - div: signed; LO=quotient truncated toward zero, HI=remainder with the sign of the dividend.
  - divu: unsigned.
- Div boundaries:
  - B==0: HI=A, LO=all ones (both signed and unsigned).
  - Signed A==most-negative and B==-1: LO=most-negative, HI=0.
  - Neither case raises an exception.
- mthi/mtlo (ops 4,5):
  - In IDLE with start=1 and req=0: write A to HI/LO at that edge.
  - Single-cycle; busy stays 0.
- req=1: start is fully suppressed for that cycle, with no accept and no mthi/mtlo write. An operation already in RUN is unaffected and completes normally.
- start while busy:
  - Ignored; no re-latch and no HI/LO write.
  - Upstream holds the instruction in E via stall_md until busy falls, then re-presents it.
- mfhi/mflo: mdu_out reflects the current HI/LO registers. While busy, the old values are shown; hazard control stalls on stall_md.
- Simultaneous completion edge with a new start in the same cycle:
  - The new start is ignored, because busy=1 that cycle.
  - It is accepted on the following cycle, back-to-back with no extra bubble.
- Reset asserted mid-RUN: immediate abort; HI/LO cleared to 0; pending results discarded.
- All widths scale with WIDTH. Products are computed at 2*WIDTH with no truncation before the split.

Test Plan:
- mult, A=32'hFFFF_FFFE (-2), B=3, MULT_CYCLES=5:
  - busy high for 5 cycles;
  - then HI=32'hFFFF_FFFF, LO=32'hFFFF_FFFA;
  - HI/LO unchanged (still old values) during busy.
- multu, A=32'hFFFF_FFFF, B=32'hFFFF_FFFF: HI=32'hFFFF_FFFE, LO=1. Then divu, A=7, B=0: HI=7, LO=32'hFFFF_FFFF after 10 busy cycles.
- div signed:
  - A=-7, B=2 gives LO=-3 (32'hFFFF_FFFD), HI=-1;
  - A=32'h8000_0000, B=-1 gives LO=32'h8000_0000, HI=0.
- start=1 op=0 with req=1:
  - busy stays 0 and HI/LO unchanged;
  - the same stimulus with req=1 during RUN still completes with the correct result.
- Start held high during busy (stall model):
  - op accepted only once;
  - a second mult presented on the completion cycle is accepted the next cycle;
  - mthi A=32'h1234 while busy is ignored; in IDLE, HI=32'h1234 next edge with busy=0.
- reset pulsed low for 1 ns mid-RUN (asynchronous, between edges): busy=0 and HI=LO=0 immediately; the next op behaves normally.
- WIDTH=16 instance: mult A=16'h8000, B=16'h8000 gives HI=16'h4000, LO=0.
